// File: rtl/sys_array_lock_arbiter.sv
// Round-robin lock arbiter sharing one systolic-array channel among NREQ threads.
// Latches the owner's payload, pulses start, holds the grant until the controller finishes.
module sys_array_lock_arbiter #(
    parameter int BITWIDTH      = 32,
    parameter int NREQ          = 2,
    parameter int PAYLOAD_WORDS = 3
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [NREQ-1:0]                         lock_req,
    input  logic [NREQ*PAYLOAD_WORDS*BITWIDTH-1:0]  req_payload,
    output logic [NREQ-1:0]                         lock_res,
    output logic                                    ctrl_start,
    output logic [PAYLOAD_WORDS*BITWIDTH-1:0]       ctrl_payload,
    input  logic                                    ctrl_finished,
    output logic                                    busy,
    output logic [2:0]                              owner,
    output logic                                    spurious_finished
);

    localparam int PW = PAYLOAD_WORDS * BITWIDTH;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_RELEASE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_owner_inc;
    logic            w_found;
    logic            w_owner_req;
    logic [PW-1:0]   r_payload;
    logic [PW-1:0]   w_sel_payload;
    logic            r_spurious;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (lock_req[IW'((int'(r_rr_ptr) + k) % NREQ)]) begin
                w_found = 1'b1;
                w_win   = IW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_sel_payload = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IW'(i)) begin
                w_sel_payload = req_payload[i*PW +: PW];
            end
        end
    end

    assign w_owner_req = lock_req[r_owner];
    assign w_owner_inc = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_found) w_next = S_START;
            S_START:   w_next = ctrl_finished ? S_RELEASE : S_BUSY;
            S_BUSY:    if (ctrl_finished) w_next = S_RELEASE;
            S_RELEASE: if (!w_owner_req) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_payload  <= '0;
            r_spurious <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_found) begin
                r_owner   <= w_win;
                r_payload <= w_sel_payload;
            end
            if (r_state == S_RELEASE && !w_owner_req) begin
                r_rr_ptr <= w_owner_inc;
            end
            if (ctrl_finished && (r_state == S_IDLE || r_state == S_RELEASE)) begin
                r_spurious <= 1'b1;
            end
        end
    end

    always_comb begin
        lock_res = '0;
        if (r_state == S_START || r_state == S_BUSY) begin
            lock_res[r_owner] = 1'b1;
        end
    end

    always_comb begin
        owner         = '0;
        owner[IW-1:0] = r_owner;
    end

    assign ctrl_start        = (r_state == S_START);
    assign busy              = (r_state != S_IDLE);
    assign ctrl_payload      = r_payload;
    assign spurious_finished = r_spurious;

endmodule

// File: tb/tb_sys_array_lock_arbiter.sv
// Bench for sys_array_lock_arbiter: vector table, directed corner sequences,
// and randomized traffic against a behavioural ownership model.
module tb_sys_array_lock_arbiter;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   lock_req = 2'b00;
    logic [191:0] req_payload = '0;
    logic [1:0]   lock_res;
    logic         ctrl_start;
    logic [95:0]  ctrl_payload;
    logic         ctrl_finished = 1'b0;
    logic         busy;
    logic [2:0]   owner;
    logic         spurious_finished;

    int n_checks = 0;
    int n_fail = 0;

    sys_array_lock_arbiter #(
        .BITWIDTH(32),
        .NREQ(2),
        .PAYLOAD_WORDS(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .lock_req(lock_req),
        .req_payload(req_payload),
        .lock_res(lock_res),
        .ctrl_start(ctrl_start),
        .ctrl_payload(ctrl_payload),
        .ctrl_finished(ctrl_finished),
        .busy(busy),
        .owner(owner),
        .spurious_finished(spurious_finished)
    );

    always #5 clock = ~clock;

    function automatic logic [95:0] mk3(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return {c, b, a};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Behavioural model: who holds the lock, whether it is the first held
    // cycle, and whether the holder is still waiting to drop its request.
    bit          m_hold = 0;
    bit          m_first = 0;
    bit          m_rel = 0;
    int          m_last = 0;
    int          m_rr = 0;
    logic [95:0] m_pay = '0;
    bit          m_spur = 0;

    function automatic int pick(input logic [1:0] r, input int rr);
        for (int k = 0; k < 2; k++) begin
            if (((r >> ((rr + k) % 2)) & 2'b01) != 2'b00) return (rr + k) % 2;
        end
        return -1;
    endfunction

    always @(posedge clock) begin
        int w;
        if (reset) begin
            m_hold  <= 0;
            m_first <= 0;
            m_rel   <= 0;
            m_last  <= 0;
            m_rr    <= 0;
            m_pay   <= '0;
            m_spur  <= 0;
        end else begin
            m_first <= 0;
            if (m_rel) begin
                if (ctrl_finished) m_spur <= 1;
                if (((lock_req >> m_last) & 2'b01) == 2'b00) begin
                    m_rel <= 0;
                    m_rr  <= (m_last + 1) % 2;
                end
            end else if (m_hold) begin
                if (ctrl_finished) begin
                    m_hold <= 0;
                    m_rel  <= 1;
                end
            end else begin
                if (ctrl_finished) m_spur <= 1;
                w = pick(lock_req, m_rr);
                if (w >= 0) begin
                    m_hold  <= 1;
                    m_first <= 1;
                    m_last  <= w;
                    m_pay   <= (w == 0) ? req_payload[95:0] : req_payload[191:96];
                end
            end
        end
    end

    task automatic check_model(input string name);
        logic [1:0] elr;
        elr = m_hold ? ((m_last == 0) ? 2'b01 : 2'b10) : 2'b00;
        check(name,
              {lock_res, ctrl_start, busy, owner, spurious_finished, ctrl_payload},
              {elr, m_hold & m_first, m_hold | m_rel, 3'(m_last), m_spur, m_pay});
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic        fin;
        logic [1:0]  lr;
        logic        st;
        logic        bsy;
        logic [2:0]  own;
        logic        sp;
        logic [95:0] pay;
    } vec_t;

    function automatic vec_t mkv(input logic rst, input logic [1:0] req, input logic fin,
                                 input logic [1:0] lr, input logic st, input logic bsy,
                                 input logic [2:0] own, input logic sp, input logic [95:0] pay);
        vec_t v;
        v.rst = rst; v.req = req; v.fin = fin; v.lr = lr; v.st = st;
        v.bsy = bsy; v.own = own; v.sp = sp; v.pay = pay;
        return v;
    endfunction

    vec_t tbl[27];

    initial begin
        logic [95:0] p0, p1, z, dead;
        logic [1:0]  prev;
        int          cnt, n;

        p0   = mk3(32'h10, 32'h20, 32'h30);
        p1   = mk3(32'h40, 32'h50, 32'h60);
        z    = '0;
        dead = mk3(32'hDEAD, 32'hDEAD, 32'hDEAD);

        tbl[0]  = mkv(1, 2'b00, 0, 2'b00, 0, 0, 0, 0, z);
        tbl[1]  = mkv(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, z);
        tbl[2]  = mkv(0, 2'b01, 0, 2'b01, 1, 1, 0, 0, p0);
        tbl[3]  = mkv(0, 2'b01, 0, 2'b01, 0, 1, 0, 0, p0);
        tbl[4]  = mkv(0, 2'b01, 0, 2'b01, 0, 1, 0, 0, p0);
        tbl[5]  = mkv(0, 2'b01, 0, 2'b01, 0, 1, 0, 0, p0);
        tbl[6]  = mkv(0, 2'b01, 0, 2'b01, 0, 1, 0, 0, p0);
        tbl[7]  = mkv(0, 2'b01, 1, 2'b00, 0, 1, 0, 0, p0);
        tbl[8]  = mkv(0, 2'b01, 0, 2'b00, 0, 1, 0, 0, p0);
        tbl[9]  = mkv(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, p0);
        tbl[10] = mkv(0, 2'b10, 0, 2'b10, 1, 1, 1, 0, p1);
        tbl[11] = mkv(0, 2'b00, 1, 2'b00, 0, 1, 1, 0, p1);
        tbl[12] = mkv(0, 2'b01, 0, 2'b00, 0, 0, 1, 0, p1);
        tbl[13] = mkv(0, 2'b01, 0, 2'b01, 1, 1, 0, 0, p0);
        tbl[14] = mkv(0, 2'b00, 0, 2'b01, 0, 1, 0, 0, p0);
        tbl[15] = mkv(0, 2'b00, 0, 2'b01, 0, 1, 0, 0, p0);
        tbl[16] = mkv(0, 2'b00, 1, 2'b00, 0, 1, 0, 0, p0);
        tbl[17] = mkv(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, p0);
        tbl[18] = mkv(0, 2'b00, 1, 2'b00, 0, 0, 0, 1, p0);
        tbl[19] = mkv(0, 2'b00, 0, 2'b00, 0, 0, 0, 1, p0);
        tbl[20] = mkv(0, 2'b11, 0, 2'b10, 1, 1, 1, 1, p1);
        tbl[21] = mkv(0, 2'b11, 0, 2'b10, 0, 1, 1, 1, p1);
        tbl[22] = mkv(1, 2'b11, 0, 2'b00, 0, 0, 0, 0, z);
        tbl[23] = mkv(0, 2'b11, 0, 2'b01, 1, 1, 0, 0, p0);
        tbl[24] = mkv(0, 2'b11, 1, 2'b00, 0, 1, 0, 0, p0);
        tbl[25] = mkv(0, 2'b10, 0, 2'b00, 0, 0, 0, 0, p0);
        tbl[26] = mkv(0, 2'b10, 0, 2'b10, 1, 1, 1, 0, p1);

        step();
        step();

        req_payload = {p1, p0};
        foreach (tbl[i]) begin
            reset         = tbl[i].rst;
            lock_req      = tbl[i].req;
            ctrl_finished = tbl[i].fin;
            step();
            check($sformatf("vec%0d", i),
                  {lock_res, ctrl_start, busy, owner, spurious_finished, ctrl_payload},
                  {tbl[i].lr, tbl[i].st, tbl[i].bsy, tbl[i].own, tbl[i].sp, tbl[i].pay});
        end
        ctrl_finished = 0;

        // Two greedy threads: each drops for one cycle when its grant clears.
        reset = 1;
        lock_req = 2'b00;
        step();
        reset = 0;
        lock_req = 2'b11;
        prev = 2'b00;
        cnt = 0;
        n = 0;
        for (int c = 0; c < 80 && n < 4; c++) begin
            step();
            if (ctrl_start) begin
                check($sformatf("rr_order%0d", n), 128'(owner), 128'(n % 2));
                n++;
                cnt = 0;
            end else if (lock_res != 2'b00) begin
                cnt++;
            end
            ctrl_finished = (lock_res != 2'b00) && (cnt == 1);
            for (int i = 0; i < 2; i++) begin
                lock_req[i] = !(prev[i] && !lock_res[i]);
            end
            prev = lock_res;
        end
        check("rr_grants", 128'(n), 128'(4));
        ctrl_finished = 0;

        // Payload must stay latched while thread 1 owns the lock.
        reset = 1;
        lock_req = 2'b00;
        step();
        reset = 0;
        req_payload = {mk3(32'h1, 32'h2, 32'h3), mk3(32'h7, 32'h8, 32'h9)};
        lock_req = 2'b10;
        step();
        check("iso_start", {ctrl_start, owner, ctrl_payload}, {1'b1, 3'd1, mk3(32'h1, 32'h2, 32'h3)});
        step();
        req_payload = {dead, dead};
        step();
        step();
        check("iso_busy", {lock_res, ctrl_payload}, {2'b10, mk3(32'h1, 32'h2, 32'h3)});
        ctrl_finished = 1;
        step();
        ctrl_finished = 0;
        lock_req = 2'b00;
        step();
        check("iso_idle", {busy, ctrl_payload}, {1'b0, mk3(32'h1, 32'h2, 32'h3)});
        lock_req = 2'b10;
        step();
        check("iso_regrant", {ctrl_start, ctrl_payload}, {1'b1, dead});

        // Random traffic against the model.
        reset = 1;
        lock_req = 2'b00;
        step();
        for (int c = 0; c < 600; c++) begin
            reset         = ($urandom_range(0, 99) == 0);
            lock_req      = 2'($urandom);
            ctrl_finished = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) begin
                req_payload = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
            step();
            check_model($sformatf("rand%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
